rsa_exp_sequencer: RTL and testbench

//  Hardware left-to-right binary exponentiation sequencer; replaces host-driven per-bit command loop.

---
 rtl/rsa_exp_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_rsa_exp_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_sequencer.sv
// rsa_exp_sequencer: left-to-right binary exponentiation sequencer.
// It latches the exponent and length on start. It then issues Montgomery
// operations to the modmul engine in this order: TO_MONT, then per exponent
// bit SQR and an optional MUL, then FROM_MONT. Each operation uses a
// valid/ready request followed by a done pulse from the engine.
// Optional feature: define RSA_EXP_CONST_TIME_EN for constant-time mode.
// In that mode every bit issues a MUL, and the MULs for zero bits are
// flagged with op_dummy so the engine discards their result.
module rsa_exp_sequencer #(
  parameter int E_WIDTH = 16,
  parameter int LEN_W   = $clog2(E_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [E_WIDTH-1:0] exponent,
  input  logic [LEN_W-1:0]   e_len,
  output logic               op_valid,
  output logic [1:0]         op_code,
  output logic               op_dummy,
  input  logic               op_ready,
  input  logic               op_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LEN_W-1:0]   bit_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_TO_MONT   = 2'd0;
  localparam logic [1:0] OP_SQR       = 2'd1;
  localparam logic [1:0] OP_MUL       = 2'd2;
  localparam logic [1:0] OP_FROM_MONT = 2'd3;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(E_WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

`ifdef RSA_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic [E_WIDTH-1:0] r_exp, w_exp_nxt;
  logic [LEN_W-1:0]   r_bit_idx, w_bit_idx_nxt;
  logic               r_err, w_err_nxt;
  logic               r_abort_pend, w_abort_pend_nxt;

  logic               w_len_ok;
  logic               w_cur_bit;
  logic               w_bit_last;
  logic               w_mul_needed;

  // Decode helpers: length validity and the exponent bit currently in play.
  always_comb begin
    w_len_ok     = (e_len != '0) && (e_len <= LEN_MAX);
    w_cur_bit    = |(r_exp & (E_WIDTH'(1) << r_bit_idx));
    w_bit_last   = (r_bit_idx == '0);
    w_mul_needed = CONST_TIME || w_cur_bit;
  end

  // State and latched run context; cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_op         <= OP_TO_MONT;
      r_exp        <= '0;
      r_bit_idx    <= '0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_exp        <= w_exp_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_err        <= w_err_nxt;
      r_abort_pend <= w_abort_pend_nxt;
    end
  end

  // Next-state sequencing of the operation list and the engine handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_exp_nxt        = r_exp;
    w_bit_idx_nxt    = r_bit_idx;
    w_err_nxt        = r_err;
    w_abort_pend_nxt = r_abort_pend;
    op_valid         = 1'b0;
    op_code          = 2'b00;
    op_dummy         = 1'b0;
    busy             = (r_state != S_IDLE);
    done             = (r_state == S_DONE);

    case (r_state)
      S_IDLE: begin
        // A start here wins over a simultaneous abort; abort alone is ignored.
        if (start) begin
          w_err_nxt        = 1'b0;
          w_abort_pend_nxt = 1'b0;
          if (w_len_ok) begin
            w_exp_nxt     = exponent;
            w_bit_idx_nxt = e_len - LEN_ONE;
            w_op_nxt      = OP_TO_MONT;
            w_state_nxt   = S_ISSUE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        // Abort before acceptance withdraws the request in the same cycle.
        if (abort) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          op_valid = 1'b1;
          op_code  = r_op;
`ifdef RSA_EXP_CONST_TIME_EN
          op_dummy = (r_op == OP_MUL) && !w_cur_bit;
`else
          op_dummy = 1'b0;
`endif
          if (op_ready) begin
            w_state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // The engine owns the accepted op, so an abort is only remembered here.
        if (abort) begin
          w_abort_pend_nxt = 1'b1;
        end
        if (op_done) begin
          if (abort || r_abort_pend) begin
            w_abort_pend_nxt = 1'b0;
            w_err_nxt        = 1'b1;
            w_state_nxt      = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
            case (r_op)
              OP_TO_MONT: begin
                w_op_nxt = OP_SQR;
              end
              OP_SQR: begin
                if (w_mul_needed) begin
                  w_op_nxt = OP_MUL;
                end else if (w_bit_last) begin
                  w_op_nxt = OP_FROM_MONT;
                end else begin
                  w_bit_idx_nxt = r_bit_idx - LEN_ONE;
                  w_op_nxt      = OP_SQR;
                end
              end
              OP_MUL: begin
                if (w_bit_last) begin
                  w_op_nxt = OP_FROM_MONT;
                end else begin
                  w_bit_idx_nxt = r_bit_idx - LEN_ONE;
                  w_op_nxt      = OP_SQR;
                end
              end
              default: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = S_DONE;
              end
            endcase
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign err     = r_err;
  assign bit_idx = r_bit_idx;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Directed bench for rsa_exp_sequencer with a behavioural modmul engine responder.
module tb_rsa_exp_sequencer;

  localparam int E_WIDTH = 16;
  localparam int LEN_W   = 5;
`ifdef RSA_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic               clk      = 1'b0;
  logic               resetn   = 1'b0;
  logic               start    = 1'b0;
  logic               abort    = 1'b0;
  logic [E_WIDTH-1:0] exponent = '0;
  logic [LEN_W-1:0]   e_len    = '0;
  logic               op_ready = 1'b0;
  logic               op_done  = 1'b0;
  logic               op_valid;
  logic [1:0]         op_code;
  logic               op_dummy;
  logic               busy;
  logic               done;
  logic               err;
  logic [LEN_W-1:0]   bit_idx;

  rsa_exp_sequencer #(.E_WIDTH(E_WIDTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .abort    (abort),
    .exponent (exponent),
    .e_len    (e_len),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_dummy (op_dummy),
    .op_ready (op_ready),
    .op_done  (op_done),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bit_idx  (bit_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rlat = 0;
  int dlat = 1;
  int abort_op = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_done_cyc = -1;
  int vld_cnt = 0;
  int busy_at_done = 0;
  int hold = 0;
  int dtimer = 0;
  bit abort_next = 1'b0;
  int first_code = 0;
  int first_dummy = 0;
  int log_code[$];
  int log_dummy[$];
  int exp_code[$];
  int exp_dummy[$];

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // Engine responder: sampled and driven on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        op_ready   = 1'b0;
        op_done    = 1'b0;
        abort      = 1'b0;
        dtimer     = 0;
        hold       = 0;
        abort_next = 1'b0;
      end else begin
        op_done = 1'b0;
        abort   = 1'b0;
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc     = cyc;
            busy_at_done = int'(busy);
          end
        end
        if (op_valid) vld_cnt++;
        if (dtimer > 0) begin
          dtimer--;
          if (dtimer == 0) begin
            op_done       = 1'b1;
            last_done_cyc = cyc;
          end
        end
        if (abort_next) begin
          abort      = 1'b1;
          abort_next = 1'b0;
        end
        op_ready = 1'b0;
        if (op_valid) begin
          if (hold == 0) begin
            first_code  = int'(op_code);
            first_dummy = int'(op_dummy);
          end else begin
            chk("hold_code", int'(op_code), first_code);
            chk("hold_dummy", int'(op_dummy), first_dummy);
          end
          if (hold >= rlat) begin
            op_ready = 1'b1;
            log_code.push_back(int'(op_code));
            log_dummy.push_back(int'(op_dummy));
            dtimer = dlat;
            hold   = 0;
            if (log_code.size() == abort_op) abort_next = 1'b1;
          end else begin
            hold++;
          end
        end
      end
    end
  end

  // Reference op list for a run (TO_MONT, per-bit SQR [+MUL], FROM_MONT).
  task automatic build_exp(input logic [E_WIDTH-1:0] ex, input int len);
    exp_code.delete();
    exp_dummy.delete();
    exp_code.push_back(0); exp_dummy.push_back(0);
    for (int i = len - 1; i >= 0; i--) begin
      exp_code.push_back(1); exp_dummy.push_back(0);
      if (ex[i] || CT) begin
        exp_code.push_back(2);
        exp_dummy.push_back((CT && !ex[i]) ? 1 : 0);
      end
    end
    exp_code.push_back(3); exp_dummy.push_back(0);
  endtask

  task automatic compare_seq(input string t, input logic [E_WIDTH-1:0] ex, input int len);
    int n;
    build_exp(ex, len);
    chk({t, "_nops"}, log_code.size(), exp_code.size());
    n = (log_code.size() < exp_code.size()) ? log_code.size() : exp_code.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_code%0d", t, i), log_code[i], exp_code[i]);
      chk($sformatf("%s_dummy%0d", t, i), log_dummy[i], exp_dummy[i]);
    end
  endtask

  task automatic run(input logic [E_WIDTH-1:0] ex, input logic [LEN_W-1:0] len,
                     input int rl, input int dl, input int ab);
    int n;
    log_code.delete();
    log_dummy.delete();
    rlat = rl; dlat = dl; abort_op = ab;
    done_cnt = 0; done_cyc = -1; last_done_cyc = -1; vld_cnt = 0;
    @(negedge clk); #2;
    start = 1'b1; exponent = ex; e_len = len;
    @(negedge clk); #2;
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("run_finished", int'(done_cnt != 0), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic bad_len(input string t, input logic [LEN_W-1:0] len);
    vld_cnt = 0;
    @(negedge clk); #2;
    start = 1'b1; e_len = len; exponent = '1;
    @(negedge clk); #1;
    chk({t, "_done"}, int'(done), 1);
    chk({t, "_err"}, int'(err), 1);
    #1 start = 1'b0;
    @(negedge clk); #1;
    chk({t, "_done_low"}, int'(done), 0);
    chk({t, "_busy_low"}, int'(busy), 0);
    chk({t, "_err_held"}, int'(err), 1);
    chk({t, "_no_valid"}, vld_cnt, 0);
  endtask

  task automatic t1_checks(input string t);
    int nd;
    nd = 0;
    foreach (log_dummy[i]) nd += log_dummy[i];
    compare_seq(t, 16'h9985, 16);
    chk({t, "_ops"}, log_code.size(), CT ? 34 : 25);
    chk({t, "_dummies"}, nd, CT ? 9 : 0);
    chk({t, "_done_cnt"}, done_cnt, 1);
    chk({t, "_err"}, int'(err), 0);
    chk({t, "_done_lat"}, done_cyc - last_done_cyc, 1);
    chk({t, "_busy_at_done"}, busy_at_done, 1);
    chk({t, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int bidx;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", int'({op_valid, op_code, op_dummy, busy, done, err, bit_idx}), 0);
    #1 resetn = 1'b1;

    // T1: full run with immediate engine
    run(16'h9985, 5'd16, 0, 1, 0);
    t1_checks("t1");

    // T3: illegal lengths
    bad_len("t3_len0", 5'd0);
    bad_len("t3_len17", 5'd17);

    // T4: slow op_ready, short exponent
    run(16'h0003, 5'd2, 5, 1, 0);
    compare_seq("t4", 16'h0003, 2);
    chk("t4_ops", log_code.size(), 6);
    chk("t4_err", int'(err), 0);
    chk("t4_done_cnt", done_cnt, 1);

    // T5: abort during 4th op's WAIT
    run(16'h9985, 5'd16, 0, 3, 4);
    chk("t5_ops", log_code.size(), 4);
    chk("t5_err", int'(err), 1);
    chk("t5_done_lat", done_cyc - last_done_cyc, 1);
    chk("t5_done_cnt", done_cnt, 1);

    // T5b: abort coincident with op_done
    run(16'hFFFF, 5'd16, 0, 1, 2);
    chk("t5b_ops", log_code.size(), 2);
    chk("t5b_err", int'(err), 1);
    chk("t5b_done_lat", done_cyc - last_done_cyc, 1);

    // T6: start while busy, then async reset mid-MUL WAIT
    log_code.delete(); log_dummy.delete();
    rlat = 0; dlat = 6; abort_op = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk); #2;
    start = 1'b1; exponent = 16'h9985; e_len = 5'd16;
    @(negedge clk); #2;
    start = 1'b0;
    n = 0;
    while (!(log_code.size() >= 3 && log_code[log_code.size()-1] == 2 && !op_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_mul_wait", int'(n < 500), 1);
    bidx = int'(bit_idx);
    #2;
    start = 1'b1; exponent = 16'h0000; e_len = 5'd3;
    @(negedge clk); #1;
    chk("t6_busy_kept", int'(busy), 1);
    chk("t6_bit_idx_kept", int'(bit_idx), bidx);
    chk("t6_still_wait", int'(op_valid), 0);
    chk("t6_no_done", done_cnt, 0);
    #1 start = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("t6_async_rst", int'({op_valid, op_code, op_dummy, busy, done, err, bit_idx}), 0);
    @(negedge clk); #2;
    resetn = 1'b1;
    run(16'h9985, 5'd16, 0, 1, 0);
    t1_checks("t6_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
